// File: rtl/tft_lcd_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tft_lcd_bus_ctrl
// Purpose  : Avalon-MM slave that queues command/data words in a small FIFO
//            and replays them onto an 8080-style TFT LCD write bus with
//            programmable strobe-low and hold timing.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            address[1:0]       - 0 cmd write, 1 data write, 2 status, 3 ctrl
//            chipselect,write_n - Avalon write qualifiers
//            writedata[15:0]    - Avalon write data
//            readdata[15:0]     - combinational register readback
//            waitrequest        - only with TFT_LCD_WAITREQ_EN defined
//            lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data[15:0]
// Option   : TFT_LCD_WAITREQ_EN - stall full-FIFO writes instead of dropping
// Revision : 1.0 - initial release
// ============================================================================
module tft_lcd_bus_ctrl #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
`ifdef TFT_LCD_WAITREQ_EN
    output logic        waitrequest,
`endif
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic        lcd_rst_n,
    output logic [15:0] lcd_data
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]          c_LOW_LOAD  = 4'(WR_LOW_CYCLES - 1);
    localparam logic [3:0]          c_HIGH_LOAD = 4'(WR_HIGH_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    // FIFO storage: {rs, data}
    logic [16:0]         r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_ovf;
    logic                r_ctrl;

    logic                w_wr_acc;
    logic                w_push_req;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_hold_done;
    logic                w_pop;
    logic                w_busy;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic [4:0]          w_level;
    logic [16:0]         w_head;

    assign w_wr_acc    = chipselect && !write_n;
    assign w_push_req  = w_wr_acc && !address[1];
    // Full/empty come from the pre-edge count, so a same-edge pop never
    // rescues a push into a full FIFO.
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = w_push_req && !w_full;
    assign w_hold_done = (r_state == c_ST_HOLD) && (r_cnt == 4'd0);
    assign w_pop       = !w_empty && ((r_state == c_ST_IDLE) || w_hold_done);
    assign w_busy      = (r_state != c_ST_IDLE) || !w_empty;
    assign w_level     = 5'(r_count);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_ovf_clr   = w_wr_acc && (address == 2'd2) && writedata[2];

`ifdef TFT_LCD_WAITREQ_EN
    // A stalled write is simply re-presented by the master until it fits.
    assign waitrequest = w_push_req && w_full;
    assign w_ovf_set   = 1'b0;
`else
    assign w_ovf_set   = w_push_req && w_full;
`endif

    assign lcd_rd_n  = 1'b1;
    assign lcd_rst_n = r_ctrl;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {address[0], writedata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_ctrl   <= 1'b0;
            r_state  <= c_ST_IDLE;
            r_cnt    <= 4'd0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // A rejection on the same edge as a clear keeps the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_wr_acc && (address == 2'd3)) begin
                r_ctrl <= writedata[0];
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state            <= c_ST_SETUP;
                        lcd_cs_n           <= 1'b0;
                        lcd_wr_n           <= 1'b1;
                        {lcd_rs, lcd_data} <= w_head;
                    end
                end
                c_ST_SETUP: begin
                    r_state  <= c_ST_STROBE;
                    lcd_wr_n <= 1'b0;
                    r_cnt    <= c_LOW_LOAD;
                end
                c_ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= c_ST_HOLD;
                        lcd_wr_n <= 1'b1;
                        r_cnt    <= c_HIGH_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        if (w_pop) begin
                            // Back-to-back: chip select stays low.
                            r_state            <= c_ST_SETUP;
                            {lcd_rs, lcd_data} <= w_head;
                        end else begin
                            r_state  <= c_ST_IDLE;
                            lcd_cs_n <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    lcd_cs_n <= 1'b1;
                    lcd_wr_n <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        readdata = 16'h0000;
        case (address)
            2'd2:    readdata = {8'h00, w_level, r_ovf, w_full, w_busy};
            2'd3:    readdata = {15'h0000, r_ctrl};
            default: readdata = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tft_lcd_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_lcd_bus_ctrl
// Purpose  : Scoreboard bench for tft_lcd_bus_ctrl. Directed writes push the
//            expected {rs,data} words; a monitor pops and compares on every
//            falling lcd_wr_n and checks strobe width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_lcd_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n;
    logic [15:0] lcd_data;
`ifdef TFT_LCD_WAITREQ_EN
    logic        waitrequest;
`endif

    int          total = 0;
    int          bad   = 0;
    int          stall_cycles = 0;
    logic [16:0] exp_q [$];
    logic [16:0] exp_word;
    logic        prev_wr = 1'b1;
    int          low_cnt = 0;

    always #5 clk = ~clk;

    tft_lcd_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
`ifdef TFT_LCD_WAITREQ_EN
        .waitrequest(waitrequest),
`endif
        .lcd_cs_n   (lcd_cs_n),
        .lcd_rs     (lcd_rs),
        .lcd_wr_n   (lcd_wr_n),
        .lcd_rd_n   (lcd_rd_n),
        .lcd_rst_n  (lcd_rst_n),
        .lcd_data   (lcd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every falling write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b1;
            low_cnt = 0;
        end else begin
            if (prev_wr && !lcd_wr_n) begin
                low_cnt = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {15'h0, lcd_rs, lcd_data}, 32'h0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("sb_word", {15'h0, lcd_rs, lcd_data}, {15'h0, exp_word});
                end
                check("cs_in_strobe", {31'h0, lcd_cs_n}, 32'h0);
            end else if (!lcd_wr_n) begin
                low_cnt++;
            end else if (!prev_wr && lcd_wr_n) begin
                check("strobe_width", low_cnt, 2);
            end
            prev_wr = lcd_wr_n;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        int   guard;
        logic stall;
        guard = 0;
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        forever begin
            #1;
`ifdef TFT_LCD_WAITREQ_EN
            stall = waitrequest;
`else
            stall = 1'b0;
`endif
            @(posedge clk);
            if (!stall) break;
            stall_cycles++;
            guard++;
            if (guard > 100) begin
                check("waitreq_timeout", 32'd1, 32'd0);
                break;
            end
        end
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_idle();
        logic [15:0] s;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            bus_read(2'd2, s);
            if (!s[0]) break;
            n++;
            if (n > 300) begin
                check("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [6:0]  wr_bits, cs_bits;
        logic [16:0] fall_mask;
        logic        p;
        int          cs_high;

        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cs_n",  {31'h0, lcd_cs_n},  32'd1);
        check("rst_wr_n",  {31'h0, lcd_wr_n},  32'd1);
        check("rst_rd_n",  {31'h0, lcd_rd_n},  32'd1);
        check("rst_lcd_rst_n", {31'h0, lcd_rst_n}, 32'd0);
        check("rst_data",  {15'h0, lcd_rs, lcd_data}, 32'd0);
        reset = 1'b0;
        bus_read(2'd2, rd);
        check("rst_status", {16'h0, rd}, 32'h0);

        // Single command write with default timing.
        exp_q.push_back({1'b0, 16'h002C});
        bus_write(2'd0, 16'h002C);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr_bits[i] = lcd_wr_n;
            cs_bits[i] = lcd_cs_n;
        end
        check("single_wr_n_pattern", {25'h0, wr_bits}, {25'h0, 7'b1110011});
        check("single_cs_n_pattern", {25'h0, cs_bits}, {25'h0, 7'b1000001});
        wait_idle();

        // Three consecutive data writes: back-to-back transfers 5 cycles apart.
        exp_q.push_back({1'b1, 16'h1111});
        exp_q.push_back({1'b1, 16'h2222});
        exp_q.push_back({1'b1, 16'h3333});
        bus_write(2'd1, 16'h1111);
        bus_write(2'd1, 16'h2222);
        bus_write(2'd1, 16'h3333);
        fall_mask = '0; cs_high = 0; p = 1'b1;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            if (p && !lcd_wr_n) fall_mask[c] = 1'b1;
            p = lcd_wr_n;
            if (c <= 15 && lcd_cs_n) cs_high++;
            if (c == 16) check("b2b_cs_end", {31'h0, lcd_cs_n}, 32'd1);
        end
        check("b2b_fall_cycles", {15'h0, fall_mask}, 32'h1084);
        check("b2b_cs_gap", cs_high, 0);
        wait_idle();

        // Six writes in six cycles.
        for (int k = 1; k <= 6; k++) begin
`ifdef TFT_LCD_WAITREQ_EN
            exp_q.push_back({1'b1, 16'hA000 + 16'(k)});
`else
            if (k <= 5) exp_q.push_back({1'b1, 16'hA000 + 16'(k)});
`endif
            bus_write(2'd1, 16'hA000 + 16'(k));
        end
`ifdef TFT_LCD_WAITREQ_EN
        check("waitreq_seen", {31'h0, stall_cycles > 0}, 32'd1);
        wait_idle();
        bus_read(2'd2, rd);
        check("stall_no_ovf", {16'h0, rd}, 32'h0);
`else
        bus_read(2'd2, rd);
        check("ovf_status_full", {16'h0, rd}, 32'h0027);
        wait_idle();
        bus_read(2'd2, rd);
        check("ovf_status_idle", {16'h0, rd}, 32'h0004);
`endif
        bus_write(2'd2, 16'h0004);
        bus_read(2'd2, rd);
        check("ovf_cleared", {16'h0, rd}, 32'h0);

        // Control register drives the panel reset.
        bus_write(2'd3, 16'h0001);
        check("ctrl_rst_n", {31'h0, lcd_rst_n}, 32'd1);
        bus_read(2'd3, rd);
        check("ctrl_read", {16'h0, rd}, 32'h1);
        bus_read(2'd0, rd);
        check("addr0_read", {16'h0, rd}, 32'h0);
        bus_read(2'd1, rd);
        check("addr1_read", {16'h0, rd}, 32'h0);

        // Reset during STROBE with two entries still queued.
        exp_q.push_back({1'b1, 16'hB001});
        bus_write(2'd1, 16'hB001);
        bus_write(2'd1, 16'hB002);
        bus_write(2'd1, 16'hB003);
        @(negedge clk);
        #1;
        check("pre_rst_strobe", {31'h0, lcd_wr_n}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_wr_n", {31'h0, lcd_wr_n}, 32'd1);
        check("abort_cs_n", {31'h0, lcd_cs_n}, 32'd1);
        check("abort_lcd_rst_n", {31'h0, lcd_rst_n}, 32'd0);
        check("abort_data", {15'h0, lcd_rs, lcd_data}, 32'd0);
        bus_read(2'd2, rd);
        check("abort_status", {16'h0, rd}, 32'h0);
        reset = 1'b0;

        // Discarded entries must never reach the bus.
        repeat (20) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tft_lcd_bus_ctrl.md
TFT_LCD_BUS_CTRL -- requirements
Module: tft_lcd_bus_ctrl

Interface
REQ-001 The module SHALL have parameter WR_LOW_CYCLES, default 2, which sets the number of cycles lcd_wr_n is held low (legal range 1..15).
REQ-002 The module SHALL have parameter WR_HIGH_CYCLES, default 2, which sets the number of hold cycles after lcd_wr_n rises (legal range 1..15).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, which sets the number of transfer-FIFO entries (power of 2, 2..16).
REQ-004 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  2  Avalon slave word address.
REQ-007 chipselect  in  1  Avalon slave select.
REQ-008 write_n  in  1  Avalon write strobe, active low.
REQ-009 writedata  in  16  Avalon write data.
REQ-010 readdata  out  16  Avalon read data, combinational from address, zero wait states.
REQ-011 waitrequest  out  1  Avalon stall; present only under TFT_LCD_WAITREQ_EN (see REQ-032).
REQ-012 lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n  out  1 each  8080-bus chip select, register select, write strobe and read strobe.
REQ-013 lcd_rst_n  out  1  panel reset.
REQ-014 lcd_data  out  16  panel data bus.

Function
REQ-015 Register map: addr 0 = command write (rs=0); addr 1 = data write (rs=1); addr 2 = status/clear; addr 3 = control.
REQ-016 A write is accepted when chipselect && !write_n; at addr 0/1 the accepted write SHALL push {rs, writedata[15:0]} into the FIFO on that edge when the FIFO is not full.
REQ-017 Full is evaluated from the pre-edge count; a push while full SHALL be rejected even if a pop occurs on the same edge.
REQ-018 A push while the FIFO is not full SHALL be accepted even if a pop occurs on the same edge; the count is unchanged by a simultaneous push and pop.
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-020 IDLE with FIFO non-empty: pop the head entry and go to SETUP on the next edge; lcd_data/lcd_rs SHALL load from the popped entry.
REQ-021 SETUP lasts 1 cycle: lcd_cs_n=0, lcd_wr_n=1, lcd_data/lcd_rs valid.
REQ-022 STROBE lasts WR_LOW_CYCLES cycles with lcd_wr_n=0.
REQ-023 HOLD lasts WR_HIGH_CYCLES cycles with lcd_wr_n=1 and lcd_cs_n=0.
REQ-024 At the end of HOLD, if the FIFO is non-empty, the FSM SHALL pop and return to SETUP (back-to-back); otherwise it SHALL go to IDLE.
REQ-025 Transfer period = 1+WR_LOW_CYCLES+WR_HIGH_CYCLES cycles; lcd_data/lcd_rs SHALL be stable from SETUP through HOLD.
REQ-026 In IDLE: lcd_cs_n=1, lcd_wr_n=1, and lcd_data/lcd_rs hold their last values.
REQ-027 lcd_rd_n SHALL be constant 1.
REQ-028 Status read (addr 2): bit0 busy (FSM≠IDLE or FIFO non-empty), bit1 full, bit2 overflow sticky, bits[7:3] FIFO level, other bits 0.
REQ-029 Overflow SHALL set when a push is rejected for full; a write to addr 2 with writedata[2]=1 SHALL clear it; if set and clear occur on the same edge, set wins.
REQ-030 Control (addr 3): bit0 drives lcd_rst_n; readback returns it in bit0; addr 0/1 read returns 0.

Reset
REQ-031 While reset=1 at an edge: FIFO emptied, FSM=IDLE, overflow=0, lcd_rst_n=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rs=0, lcd_data=0; reset mid-transfer SHALL abort it immediately, discard pending entries, and ignore bus writes in that cycle.

Configuration
REQ-032 Macro TFT_LCD_WAITREQ_EN defined: waitrequest = chipselect && !write_n && address[1]==0 && full; the stalled write SHALL be held and accepted once not full; overflow never sets. Macro undefined: the waitrequest port SHALL be absent, and full-FIFO writes are dropped and set overflow.

Verification
REQ-033 Write addr0 0x002C, defaults -> lcd_rs=0, lcd_data=0x002C; lcd_wr_n low for 2 cycles starting 2 cycles after the write edge; lcd_cs_n low 5 cycles.
REQ-034 Write 0x1111, 0x2222, 0x3333 to addr1 on consecutive cycles -> three back-to-back transfers 5 cycles apart, lcd_cs_n never high between them, rs=1.
REQ-035 Six writes in 6 cycles with the macro undefined -> the first write pops immediately, so five entries compete for 4 slots; one write is dropped; status bit2=1; writing 0x0004 to addr2 clears it.
REQ-036 The REQ-035 stimulus with TFT_LCD_WAITREQ_EN -> waitrequest asserted while full; all 6 words appear on lcd_data in order; overflow=0.
REQ-037 Assert reset during STROBE with 2 entries queued -> next cycle lcd_wr_n=1, lcd_cs_n=1, status reads 0, lcd_rst_n=0.
REQ-038 Write 0x0001 to addr3 -> lcd_rst_n=1 after the edge; a read of addr3 returns 0x0001.
